dff_mux_sudp: RTL and testbench
===============================

# dff_mux_sudp

Small primitive-cell cluster holding the three leaf cells used at the top level of the simulation harness: a clear/preset D flip-flop, a sequential enable-register cell ("sudp" function), and a 2:1 multiplexer. All state elements share one clock and one synchronous active-high clear; the multiplexer is purely combinational. The cluster is a drop-in bundle, so top-level code instantiates one block instead of three loose cells.

## Interface
- WIDTH, 1: data width of the flip-flop, sudp cell and multiplexer paths.
- PRESET_VAL, all ones: value loaded into qval by preset.

Ports:
- clock  in  1  rising-edge clock for all state.
- clear  in  1  reset; one clock, reset is synchronous and active-high.
- preset  in  1  synchronous active-high preset of the flip-flop.
- dval  in  WIDTH  flip-flop data input.
- qval  out  WIDTH  flip-flop output.
- control  in  1  sudp load enable.
- din  in  WIDTH  sudp data input.
- udp_out  out  WIDTH  sudp registered output.
- ctl  in  1  multiplexer select.
- dA  in  WIDTH  multiplexer input, selected when ctl=0.
- dB  in  WIDTH  multiplexer input, selected when ctl=1.
- muxout  out  WIDTH  multiplexer output.

## Operation
- Flip-flop, on each rising clock: clear=1 -> qval=0; else preset=1 -> qval=PRESET_VAL; else qval=dval.
- clear has priority over preset when both are high.
- sudp cell, on each rising clock: clear=1 -> udp_out=0; else control=1 -> udp_out=din; else hold.
- preset has no effect on udp_out.
- Multiplexer: muxout = ctl ? dB : dA, combinational, no storage.
- X/Z on ctl: muxout bits equal where dA and dB agree, X elsewhere (UDP-style pessimism). Synthesis treats it as a plain mux.
- No internal arithmetic; all paths are WIDTH wide with no truncation or extension.

## Timing
- Reset values after one clock with clear=1: qval=0, udp_out=0. muxout is not reset and follows its inputs.
- Before the first clock edge, qval and udp_out are X.
- Latency: qval and udp_out update one rising edge after their inputs are sampled. muxout has zero-cycle latency.
- Inputs are sampled only at the rising edge; glitches between edges have no effect on qval or udp_out.
- Clear asserted mid-operation takes effect at the next edge and overrides any pending load or preset.
- control held low keeps udp_out indefinitely, including across preset pulses.

## Structure
- Shared package dff_mux_sudp_pkg: WIDTH default and the PRESET_VAL default constant.
- One natural sub-module, dff_cell: clocked register with sync clear, preset and enable.
  - The flip-flop uses it with enable tied high.
  - The sudp cell uses it with preset tied low and enable=control.
- Multiplexer is inline combinational logic in the top of the block.

## Test plan
- Reset: clear=1 for one edge with dval=1, control=1, din=1 -> qval=0, udp_out=0 after the edge.
- Priority: clear=1, preset=1 -> qval=0. Then clear=0, preset=1 -> qval=1 (all ones) at the next edge.
- Capture: clear=0, preset=0, dval toggles 0,1,1,0 per cycle -> qval follows with exactly one-cycle delay.
- sudp hold: control=1, din=1 -> udp_out=1. Then control=0, din=0 for 5 cycles -> udp_out stays 1. Then clear=1 -> udp_out=0.
- Mux: dA=0, dB=1; ctl=0 -> muxout=0, ctl=1 -> muxout=1 in the same timestep, no clock needed.
- Mux X-select: ctl=X with dA=dB=1 -> muxout=1. ctl=X with dA=0, dB=1 -> muxout=X.

Source files
------------

// File: rtl/dff_mux_sudp_pkg.sv
// -----------------------------------------------------------------------------
// dff_mux_sudp_pkg
// Shared constants and types for the dff_mux_sudp leaf-cell cluster.
//   DEFAULT_WIDTH    : default data width of every path in the cluster
//   PRESET_FILL_BIT  : bit replicated across the width to form the preset value
//   cell_ctl_t       : per-cycle load controls of a dff_cell (preset, enable)
// -----------------------------------------------------------------------------
package dff_mux_sudp_pkg;

   localparam int   DEFAULT_WIDTH   = 1;
   localparam logic PRESET_FILL_BIT = 1'b1;

   typedef struct packed {
      logic preset;   // load PRESET_VAL (ignored while clear is high)
      logic enable;   // load d (ignored while clear or preset is high)
   } cell_ctl_t;

endpackage : dff_mux_sudp_pkg

// File: rtl/dff_mux_sudp_dff_cell.sv
// -----------------------------------------------------------------------------
// dff_cell
// Clocked register with synchronous active-high clear, synchronous preset and
// load enable. Priority at each rising edge: clear > preset > enable > hold.
// Ports:
//   clock  in  : rising-edge clock
//   clear  in  : synchronous active-high clear, forces q to zero
//   ctl    in  : preset / enable controls (cell_ctl_t)
//   d      in  : data loaded when enable is high
//   q      out : registered value
// -----------------------------------------------------------------------------
module dff_cell
   import dff_mux_sudp_pkg::*;
#(
   parameter int               WIDTH      = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{PRESET_FILL_BIT}}
) (
   input  logic             clock,
   input  logic             clear,
   input  cell_ctl_t        ctl,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Next value for the non-clear case; clear is applied in the flop block.
   always_comb begin
      q_d = q_q;
      if (ctl.preset) begin
         q_d = PRESET_VAL;
      end else if (ctl.enable) begin
         q_d = d;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : dff_cell

// File: rtl/dff_mux_sudp.sv
// -----------------------------------------------------------------------------
// dff_mux_sudp
// Drop-in bundle of three leaf cells sharing one clock and one synchronous
// active-high clear:
//   - clear/preset D flip-flop      : dval -> qval every edge
//   - sudp enable register          : din -> udp_out when control is high
//   - 2:1 multiplexer (combinational): muxout = ctl ? dB : dA
// Ports:
//   clock    in          : rising-edge clock for all state
//   clear    in          : synchronous active-high clear (qval, udp_out -> 0)
//   preset   in          : synchronous preset of the flip-flop only
//   dval     in  [W-1:0] : flip-flop data
//   qval     out [W-1:0] : flip-flop output
//   control  in          : sudp load enable
//   din      in  [W-1:0] : sudp data
//   udp_out  out [W-1:0] : sudp registered output
//   ctl      in          : mux select (0 -> dA, 1 -> dB)
//   dA, dB   in  [W-1:0] : mux data inputs
//   muxout   out [W-1:0] : mux output
// -----------------------------------------------------------------------------
module dff_mux_sudp
   import dff_mux_sudp_pkg::*;
#(
   parameter int               WIDTH      = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{PRESET_FILL_BIT}}
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             preset,
   input  logic [WIDTH-1:0] dval,
   output logic [WIDTH-1:0] qval,
   input  logic             control,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] udp_out,
   input  logic             ctl,
   input  logic [WIDTH-1:0] dA,
   input  logic [WIDTH-1:0] dB,
   output logic [WIDTH-1:0] muxout
);

   cell_ctl_t ff_ctl;
   cell_ctl_t udp_ctl;

   // Plain flip-flop: loads every edge, so enable is tied high.
   assign ff_ctl.preset  = preset;
   assign ff_ctl.enable  = 1'b1;

   // sudp cell: preset never reaches it, control gates the load.
   assign udp_ctl.preset = 1'b0;
   assign udp_ctl.enable = control;

   dff_cell #(
      .WIDTH      (WIDTH),
      .PRESET_VAL (PRESET_VAL)
   ) u_ff (
      .clock (clock),
      .clear (clear),
      .ctl   (ff_ctl),
      .d     (dval),
      .q     (qval)
   );

   dff_cell #(
      .WIDTH      (WIDTH),
      .PRESET_VAL (PRESET_VAL)
   ) u_udp (
      .clock (clock),
      .clear (clear),
      .ctl   (udp_ctl),
      .d     (din),
      .q     (udp_out)
   );

   // The conditional operator merges bitwise on an unknown select, giving X
   // only where dA and dB differ; synthesis sees an ordinary 2:1 mux.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      assign muxout[gi] = ctl ? dB[gi] : dA[gi];
   end

endmodule : dff_mux_sudp

// File: tb/tb_dff_mux_sudp.sv
// -----------------------------------------------------------------------------
// tb_dff_mux_sudp
// Directed steps followed by random cycles; every registered output is
// compared against a behavioural model updated at each rising edge.
// -----------------------------------------------------------------------------
module tb_dff_mux_sudp;

   localparam int W = 4;
   localparam logic [W-1:0] ONES = '1;

   logic         clock = 1'b0;
   logic         clear, preset, control, ctl;
   logic [W-1:0] dval, din, dA, dB;
   logic [W-1:0] qval, udp_out, muxout;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // behavioural model of the registered outputs
   logic [W-1:0] m_q, m_udp;

   dff_mux_sudp #(.WIDTH(W)) dut (
      .clock   (clock),
      .clear   (clear),
      .preset  (preset),
      .dval    (dval),
      .qval    (qval),
      .control (control),
      .din     (din),
      .udp_out (udp_out),
      .ctl     (ctl),
      .dA      (dA),
      .dB      (dB),
      .muxout  (muxout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      assert_cnt++;
      assert (obs === exp)
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: model takes the inputs visible at the edge, outputs are
   // compared on the following falling edge.
   task automatic tick(input string tag);
      @(posedge clock);
      if (clear) begin
         m_q   = '0;
         m_udp = '0;
      end else begin
         m_q = preset ? ONES : dval;
         if (control) m_udp = din;
      end
      @(negedge clock);
      check({tag, "_qval"}, qval, m_q);
      check({tag, "_udp"}, udp_out, m_udp);
      $display("cyc %s clr=%b pre=%b dval=%b ctl=%b din=%b -> qval=%b udp=%b",
               tag, clear, preset, dval, control, din, qval, udp_out);
   endtask

   initial begin
      m_q = 'x; m_udp = 'x;
      clear = 1'b1; preset = 1'b0; control = 1'b1; ctl = 1'b0;
      dval = ONES; din = ONES; dA = '0; dB = '0;
      @(negedge clock);

      // reset with loads requested
      tick("reset");
      check("reset_q0", qval, '0);
      check("reset_u0", udp_out, '0);

      // clear beats preset, then preset alone
      clear = 1'b1; preset = 1'b1; control = 1'b0;
      tick("prio_clr");
      check("prio_clr_q", qval, '0);
      clear = 1'b0;
      tick("prio_pre");
      check("prio_pre_q", qval, ONES);

      // capture sequence
      preset = 1'b0;
      dval = '0;   tick("cap0"); check("cap0_q", qval, '0);
      dval = ONES; tick("cap1"); check("cap1_q", qval, ONES);
      dval = ONES; tick("cap2"); check("cap2_q", qval, ONES);
      dval = '0;   tick("cap3"); check("cap3_q", qval, '0);

      // sudp load, hold through preset pulses, then clear
      control = 1'b1; din = 4'b1011;
      tick("udp_load");
      check("udp_load_u", udp_out, 4'b1011);
      control = 1'b0; din = '0;
      for (int i = 0; i < 5; i++) begin
         preset = (i == 2);
         tick("udp_hold");
         check("udp_hold_u", udp_out, 4'b1011);
      end
      preset = 1'b0; clear = 1'b1;
      tick("udp_clr");
      check("udp_clr_u", udp_out, '0);
      clear = 1'b0;

      // combinational mux, no clock edge involved
      dA = 4'b0000; dB = 4'b1111; ctl = 1'b0; #1;
      check("mux_sel0", muxout, 4'b0000);
      ctl = 1'b1; #1;
      check("mux_sel1", muxout, 4'b1111);
      dA = 4'b1010; dB = 4'b1010; ctl = 1'bx; #1;
      check("mux_x_agree", muxout, 4'b1010);
      dA = 4'b0110; dB = 4'b0101; #1;
      // only meaningful where the simulator keeps X on the select
      if ($isunknown(ctl)) check("mux_x_differ", muxout, 4'b01xx);
      ctl = 1'b0;
      @(negedge clock);

      // random traffic
      for (int n = 0; n < 300; n++) begin
         clear   = ($urandom_range(15) == 0);
         preset  = ($urandom_range(7) == 0);
         control = $urandom_range(1);
         dval    = W'($urandom);
         din     = W'($urandom);
         ctl     = $urandom_range(1);
         dA      = W'($urandom);
         dB      = W'($urandom);
         #1;
         check("rnd_mux", muxout, ctl ? dB : dA);
         tick("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule : tb_dff_mux_sudp
